// File: rtl/wb_sram_model.sv
// Wishbone B4 pipelined slave memory model with an outstanding-request queue,
// bounded pseudo-random latency, random stall injection and a mailbox-write detector.
module wb_sram_model #(
  parameter int unsigned MEM_BYTES    = 2097152,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned MIN_LAT      = 1,
  parameter int unsigned LAT_MASK     = 7,
  parameter int unsigned STALL_THRESH = 0,
  parameter logic [31:0] SEED         = 32'hACE1_2345,
  parameter logic [31:0] MAILBOX_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [3:0]               wb_sel_i,
  input  logic [31:0]              wb_adr_i,
  input  logic [31:0]              wb_dat_i,
  output logic                     wb_stall_o,
  output logic                     wb_ack_o,
  output logic [31:0]              wb_dat_o,
  output logic                     mailbox_valid_o,
  output logic [31:0]              mailbox_data_o,
  output logic [$clog2(DEPTH):0]   outstanding_o
);

  localparam int unsigned AW    = $clog2(MEM_BYTES);
  localparam int unsigned WORDS = MEM_BYTES / 4;
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW    = $clog2(DEPTH) + 1;
  localparam int unsigned CW    = $clog2(MIN_LAT + LAT_MASK + 1);
  localparam logic [31:0] TAPS  = 32'h8020_0003;

  logic [31:0]   r_mem [WORDS];
  logic [31:0]   r_lfsr;
  logic [CW-1:0] r_qcnt [DEPTH];
  logic [31:0]   r_qdat [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [OW-1:0] r_occ;
  logic          r_ack;
  logic [31:0]   r_dat;
  logic          r_mb_valid;
  logic [31:0]   r_mb_data;

  logic          w_full;
  logic          w_rand_stall;
  logic          w_accept;
  logic          w_pop;
  logic          w_mb_hit;
  logic [AW-3:0] w_widx;
  logic [CW-1:0] w_newcnt;
  logic [31:0]   w_lfsr_nxt;

  function automatic logic [PW-1:0] incPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_full       = (r_occ == OW'(DEPTH));
  assign w_rand_stall = ({1'b0, r_lfsr[3:0]} < 5'(STALL_THRESH));
  assign wb_stall_o   = w_full | w_rand_stall;
  assign w_accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign w_pop        = (r_occ != '0) && (r_qcnt[r_head] == '0);
  assign w_mb_hit     = w_accept & wb_we_i & (wb_adr_i == MAILBOX_ADDR);
  assign w_widx       = wb_adr_i[AW-1:2];
  assign w_newcnt     = CW'(MIN_LAT - 1) + CW'(r_lfsr[15:8] & 8'(LAT_MASK));
  assign w_lfsr_nxt   = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

  assign wb_ack_o        = r_ack;
  assign wb_dat_o        = r_dat;
  assign mailbox_valid_o = r_mb_valid;
  assign mailbox_data_o  = r_mb_data;
  assign outstanding_o   = r_occ;

  // Writes land in memory at accept so later reads observe them before the write acks.
  always_ff @(posedge clk) begin
    if (!rst && w_accept && wb_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) r_mem[w_widx][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr     <= SEED;
      r_head     <= '0;
      r_tail     <= '0;
      r_occ      <= '0;
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_mb_valid <= 1'b0;
      r_mb_data  <= '0;
    end else begin
      r_lfsr     <= w_lfsr_nxt;
      r_mb_valid <= w_mb_hit;
      if (w_mb_hit) r_mb_data <= wb_dat_i;
      for (int i = 0; i < DEPTH; i++) begin
        if (r_qcnt[i] != '0) r_qcnt[i] <= r_qcnt[i] - CW'(1);
      end
      // Dropping cyc abandons every queued request without acking it.
      if (!wb_cyc_i) begin
        r_head <= '0;
        r_tail <= '0;
        r_occ  <= '0;
        r_ack  <= 1'b0;
        r_dat  <= '0;
      end else begin
        r_ack <= w_pop;
        r_dat <= w_pop ? r_qdat[r_head] : '0;
        if (w_pop) r_head <= incPtr(r_head);
        if (w_accept) begin
          r_qcnt[r_tail] <= w_newcnt;
          r_qdat[r_tail] <= wb_we_i ? '0 : r_mem[w_widx];
          r_tail         <= incPtr(r_tail);
        end
        if (w_accept && !w_pop)      r_occ <= r_occ + OW'(1);
        else if (!w_accept && w_pop) r_occ <= r_occ - OW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_sram_model.sv
// Scoreboard bench for wb_sram_model: three instances (fixed latency, deep latency,
// random latency/stall) share one bus; the active instance is chosen by tgt.
module tb_wb_sram_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;

  logic        stallV [3];
  logic        ackV   [3];
  logic [31:0] datV   [3];
  logic        mbV    [3];
  logic [31:0] mbD    [3];
  logic [2:0]  occV   [3];

  typedef struct {
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] refMem [1024];
  int          tgt = 0;
  int          latMin = 1;
  int          latMax = 1;
  int          cycN = 0;
  int          checks = 0;
  int          failures = 0;
  int          maxOcc = 0;
  int          lastWait = 0;
  int          waitSum;
  logic [31:0] lastRead = '0;
  logic [31:0] rnd;

  wb_sram_model #(.MEM_BYTES(4096), .DEPTH(4), .MIN_LAT(1), .LAT_MASK(0),
                  .STALL_THRESH(0), .MAILBOX_ADDR(32'h8000_1000)) dutA (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat), .wb_stall_o(stallV[0]),
    .wb_ack_o(ackV[0]), .wb_dat_o(datV[0]), .mailbox_valid_o(mbV[0]),
    .mailbox_data_o(mbD[0]), .outstanding_o(occV[0]));

  wb_sram_model #(.MEM_BYTES(4096), .DEPTH(4), .MIN_LAT(8), .LAT_MASK(0),
                  .STALL_THRESH(0)) dutB (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat), .wb_stall_o(stallV[1]),
    .wb_ack_o(ackV[1]), .wb_dat_o(datV[1]), .mailbox_valid_o(mbV[1]),
    .mailbox_data_o(mbD[1]), .outstanding_o(occV[1]));

  wb_sram_model #(.MEM_BYTES(4096), .DEPTH(4), .MIN_LAT(1), .LAT_MASK(7),
                  .STALL_THRESH(4)) dutC (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat), .wb_stall_o(stallV[2]),
    .wb_ack_o(ackV[2]), .wb_dat_o(datV[2]), .mailbox_valid_o(mbV[2]),
    .mailbox_data_o(mbD[2]), .outstanding_o(occV[2]));

  always @(posedge clk) cycN <= cycN + 1;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Pops the oldest expected response and checks data and accept-to-ack latency.
  task automatic checkOutput();
    exp_t e;
    int   lat;
    if (sb.size() == 0) begin
      checkVal("spurious_ack", 32'(ackV[tgt]), 32'd0);
    end else begin
      e = sb.pop_front();
      checkVal("ack_data", datV[tgt], e.data);
      lastRead = datV[tgt];
      lat = cycN - e.acc;
      checks++;
      assert ((lat >= latMin && lat <= latMax) === 1'b1) else begin
        failures++;
        $error("[TB] FAIL ack_latency observed=%0d expected=%0d..%0d", lat, latMin, latMax);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (int'(occV[tgt]) > maxOcc) maxOcc = int'(occV[tgt]);
      if (ackV[tgt]) checkOutput();
    end
  end

  // Presents one request from a negedge; the request is accepted at the next
  // posedge where the target is not stalling, and its expectation is queued.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [3:0] s,
                               input logic [31:0] d);
    int waits = 0;
    int idx;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
    while (stallV[tgt] === 1'b1 && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    lastWait = waits;
    if (stallV[tgt] === 1'b1) begin
      checkVal("stall_timeout", 32'(stallV[tgt]), 32'd0);
      stb = 1'b0;
      return;
    end
    idx = int'(a[11:2]);
    if (w) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) refMem[idx][8*b +: 8] = d[8*b +: 8];
      end
      sb.push_back('{data: 32'h0, acc: cycN + 1});
    end else begin
      sb.push_back('{data: refMem[idx], acc: cycN + 1});
    end
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkVal("drain_pending", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic flushBus();
    cyc = 1'b0;
    stb = 1'b0;
    @(negedge clk);
    sb.delete();
    cyc = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycN);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat = '0;
    repeat (3) @(negedge clk);
    checkVal("rst_ack", 32'(ackV[0]), 32'd0);
    checkVal("rst_dat", datV[0], 32'd0);
    checkVal("rst_occ", 32'(occV[0]), 32'd0);
    checkVal("rst_mb_valid", 32'(mbV[0]), 32'd0);
    checkVal("rst_mb_data", mbD[0], 32'd0);
    checkVal("rst_occ_b", 32'(occV[1]), 32'd0);
    rst = 1'b0;
    cyc = 1'b1;
    @(negedge clk);
    checkVal("idle_stall", 32'(stallV[0]), 32'd0);

    // Fixed single-cycle latency instance.
    applyStimulus(1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF);
    drain();
    applyStimulus(1'b0, 32'h100, 4'hF, 32'h0);
    drain();
    checkVal("read_back", lastRead, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 32'h40, 4'hF, 32'h1122_3344);
    applyStimulus(1'b1, 32'h40, 4'b0101, 32'hAABB_CCDD);
    applyStimulus(1'b0, 32'h40, 4'hF, 32'h0);
    drain();
    checkVal("byte_lanes", lastRead, 32'h11BB_33DD);
    applyStimulus(1'b1, 32'h40, 4'h0, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 32'hFFFF_F043, 4'hF, 32'h0);
    drain();
    checkVal("sel_zero_alias", lastRead, 32'h11BB_33DD);
    applyStimulus(1'b1, 32'h8000_1000, 4'hF, 32'h0000_00FF);
    checkVal("mb_valid", 32'(mbV[0]), 32'd1);
    checkVal("mb_data", mbD[0], 32'h0000_00FF);
    @(negedge clk);
    checkVal("mb_pulse_end", 32'(mbV[0]), 32'd0);
    applyStimulus(1'b1, 32'h0000_1000, 4'hF, 32'h0000_0077);
    checkVal("mb_alias_miss", 32'(mbV[0]), 32'd0);
    drain();

    // Long fixed latency: queue fills, acks stay in order.
    flushBus();
    tgt = 1; latMin = 8; latMax = 8;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'h200 + 32'(4 * i), 4'hF, 32'hB000_0000 + 32'(i));
    drain();
    maxOcc = 0;
    waitSum = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h200 + 32'(4 * i), 4'hF, 32'h0);
      waitSum += lastWait;
    end
    checkVal("no_stall_first4", 32'(waitSum), 32'd0);
    checkVal("full_stall", 32'(stallV[1]), 32'd1);
    checkVal("occ_full", 32'(occV[1]), 32'd4);
    applyStimulus(1'b0, 32'h210, 4'hF, 32'h0);
    applyStimulus(1'b0, 32'h214, 4'hF, 32'h0);
    drain();
    checkVal("occ_peak", 32'(maxOcc), 32'd4);

    // Abort with three reads in flight.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h200 + 32'(4 * i), 4'hF, 32'h0);
    cyc = 1'b0;
    sb.delete();
    @(negedge clk);
    cyc = 1'b1;
    checkVal("abort_ack", 32'(ackV[1]), 32'd0);
    checkVal("abort_occ", 32'(occV[1]), 32'd0);
    repeat (12) @(negedge clk);
    applyStimulus(1'b0, 32'h204, 4'hF, 32'h0);
    drain();
    checkVal("after_abort", lastRead, 32'hB000_0001);

    // Reset with two requests queued.
    applyStimulus(1'b0, 32'h208, 4'hF, 32'h0);
    applyStimulus(1'b0, 32'h20C, 4'hF, 32'h0);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    checkVal("rst_mid_ack", 32'(ackV[1]), 32'd0);
    checkVal("rst_mid_occ", 32'(occV[1]), 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    applyStimulus(1'b0, 32'h20C, 4'hF, 32'h0);
    drain();
    checkVal("after_reset", lastRead, 32'hB000_0003);

    // Random latency and stalls against the reference memory.
    flushBus();
    tgt = 2; latMin = 1; latMax = 8;
    for (int w = 0; w < 16; w++) applyStimulus(1'b1, 32'h400 + 32'(4 * w), 4'hF, $urandom);
    for (int n = 0; n < 1000; n++) begin
      rnd = $urandom;
      applyStimulus(rnd[0],
                    ($urandom & 32'hFFFF_F000) | (32'h400 + 32'(4 * $urandom_range(0, 15)))
                      | 32'($urandom_range(0, 3)),
                    4'($urandom), $urandom);
      if (rnd[1] & rnd[2]) @(negedge clk);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
